health_led_driver: RTL and testbench

- Multi-channel LED indicator driver; parametrised successor to the single-channel fixed-rate blinker.
- Each channel independently selects OFF, ON, BLINK (50% duty) or BURST (N short flashes then a long gap) for health/error codes.
- Sits between the health-status logic and the board LED pins.
- One shared prescaler produces a common tick, so all channels blink in phase.

---
 rtl/health_led_driver.sv | 199 +++++++++++++++++++
 tb/tb_health_led_driver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/health_led_driver.sv
// Multi-channel health/error LED driver: per-channel OFF/ON/BLINK/BURST patterns
// timed from one shared prescaler tick so all channels stay in phase.
module health_led_driver #(
    parameter int NUM_CH      = 4,
    parameter int TICK_DIV    = 500000,
    parameter int BLINK_TICKS = 25,
    parameter int BURST_ON    = 10,
    parameter int BURST_OFF   = 10,
    parameter int BURST_GAP   = 100,
    parameter int CNT_W       = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic [2*NUM_CH-1:0]       i_mode,
    input  logic [CNT_W*NUM_CH-1:0]   i_burst_cnt,
    output logic [NUM_CH-1:0]         o_led_out,
    output logic [NUM_CH-1:0]         o_frame_done,
    output logic                      o_tick
);

    // state    | meaning
    // ---------+-----------------------------------------------
    // ST_IDLE  | mode OFF, LED dark
    // ST_SOLID | mode ON, LED lit, ticks ignored
    // ST_BLINK | 50% duty blink, toggles every BLINK_TICKS ticks
    // ST_B_ON  | burst flash lit for BURST_ON ticks
    // ST_B_OFF | dark between flashes for BURST_OFF ticks
    // ST_B_GAP | dark after last flash for BURST_GAP ticks
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOLID,
        ST_BLINK,
        ST_B_ON,
        ST_B_OFF,
        ST_B_GAP
    } state_t;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;

    localparam int TC_M1  = (BLINK_TICKS > BURST_ON) ? BLINK_TICKS : BURST_ON;
    localparam int TC_M2  = (BURST_OFF > BURST_GAP) ? BURST_OFF : BURST_GAP;
    localparam int TC_MAX = (TC_M1 > TC_M2) ? TC_M1 : TC_M2;
    localparam int TC_W   = (TC_MAX > 1) ? $clog2(TC_MAX) : 1;
    localparam int PS_W   = $clog2(TICK_DIV);

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [TC_W-1:0] TC_BLINK = TC_W'(BLINK_TICKS - 1);
    localparam logic [TC_W-1:0] TC_ON    = TC_W'(BURST_ON - 1);
    localparam logic [TC_W-1:0] TC_OFF   = TC_W'(BURST_OFF - 1);
    localparam logic [TC_W-1:0] TC_GAP   = TC_W'(BURST_GAP - 1);

    logic [PS_W-1:0] r_presc;
    logic            w_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
        end else if (!i_enable) begin
            r_presc <= '0;
        end else if (r_presc == PS_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

    assign w_tick = (r_presc == PS_LAST);
    assign o_tick = w_tick;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           r_state;
        logic [1:0]       r_mode_q;
        logic [TC_W-1:0]  r_tc;
        logic [CNT_W-1:0] r_rem;
        logic             r_led;
        logic             r_fd;
        logic [1:0]       w_mode;
        logic [CNT_W-1:0] w_burst_cnt;

        assign w_mode      = i_mode[2*g +: 2];
        assign w_burst_cnt = i_burst_cnt[CNT_W*g +: CNT_W];

        // tc is a down-counter: loaded with (duration-1), the phase ends on a tick at zero
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_state  <= ST_IDLE;
                r_mode_q <= MODE_OFF;
                r_tc     <= '0;
                r_rem    <= '0;
                r_led    <= 1'b0;
                r_fd     <= 1'b0;
            end else if (!i_enable) begin
                r_state  <= ST_IDLE;
                r_mode_q <= MODE_OFF;
                r_tc     <= '0;
                r_rem    <= '0;
                r_led    <= 1'b0;
                r_fd     <= 1'b0;
            end else begin
                r_mode_q <= w_mode;
                r_fd     <= 1'b0;
                if (w_mode != r_mode_q) begin
                    case (w_mode)
                        MODE_OFF: begin
                            r_state <= ST_IDLE;
                            r_led   <= 1'b0;
                            r_tc    <= '0;
                        end
                        MODE_ON: begin
                            r_state <= ST_SOLID;
                            r_led   <= 1'b1;
                            r_tc    <= '0;
                        end
                        MODE_BLINK: begin
                            r_state <= ST_BLINK;
                            r_led   <= 1'b1;
                            r_tc    <= TC_BLINK;
                        end
                        default: begin
                            r_rem <= w_burst_cnt;
                            if (w_burst_cnt == '0) begin
                                r_state <= ST_B_GAP;
                                r_led   <= 1'b0;
                                r_tc    <= TC_GAP;
                            end else begin
                                r_state <= ST_B_ON;
                                r_led   <= 1'b1;
                                r_tc    <= TC_ON;
                            end
                        end
                    endcase
                end else if (w_tick) begin
                    case (r_state)
                        ST_BLINK: begin
                            if (r_tc == '0) begin
                                r_led <= ~r_led;
                                r_tc  <= TC_BLINK;
                            end else begin
                                r_tc <= r_tc - TC_W'(1);
                            end
                        end
                        ST_B_ON: begin
                            if (r_tc == '0) begin
                                r_state <= ST_B_OFF;
                                r_led   <= 1'b0;
                                r_rem   <= r_rem - CNT_W'(1);
                                r_tc    <= TC_OFF;
                            end else begin
                                r_tc <= r_tc - TC_W'(1);
                            end
                        end
                        ST_B_OFF: begin
                            if (r_tc == '0) begin
                                if (r_rem != '0) begin
                                    r_state <= ST_B_ON;
                                    r_led   <= 1'b1;
                                    r_tc    <= TC_ON;
                                end else begin
                                    r_state <= ST_B_GAP;
                                    r_led   <= 1'b0;
                                    r_tc    <= TC_GAP;
                                end
                            end else begin
                                r_tc <= r_tc - TC_W'(1);
                            end
                        end
                        ST_B_GAP: begin
                            // frame boundary: count is sampled only here and on entry
                            if (r_tc == '0) begin
                                r_fd  <= 1'b1;
                                r_rem <= w_burst_cnt;
                                if (w_burst_cnt == '0) begin
                                    r_state <= ST_B_GAP;
                                    r_led   <= 1'b0;
                                    r_tc    <= TC_GAP;
                                end else begin
                                    r_state <= ST_B_ON;
                                    r_led   <= 1'b1;
                                    r_tc    <= TC_ON;
                                end
                            end else begin
                                r_tc <= r_tc - TC_W'(1);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end

        assign o_led_out[g]    = r_led;
        assign o_frame_done[g] = r_fd;
    end

endmodule

// File: tb/tb_health_led_driver.sv
// Self-checking bench for health_led_driver: directed scenarios plus random mode,
// count and enable traffic, compared every cycle against a tick/pattern-level model.
module tb_health_led_driver;

    localparam int NUM_CH      = 2;
    localparam int TICK_DIV    = 4;
    localparam int BLINK_TICKS = 2;
    localparam int BURST_ON    = 1;
    localparam int BURST_OFF   = 1;
    localparam int BURST_GAP   = 3;
    localparam int CNT_W       = 4;
    localparam int PAT_MAX     = ((1 << CNT_W) - 1) * (BURST_ON + BURST_OFF) + BURST_GAP;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    enable = 1'b0;
    logic [2*NUM_CH-1:0]     mode = '0;
    logic [CNT_W*NUM_CH-1:0] burst_cnt = '0;
    logic [NUM_CH-1:0]       led_out;
    logic [NUM_CH-1:0]       frame_done;
    logic                    tick;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    health_led_driver #(
        .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .BLINK_TICKS(BLINK_TICKS),
        .BURST_ON(BURST_ON), .BURST_OFF(BURST_OFF), .BURST_GAP(BURST_GAP), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_enable(enable),
        .i_mode(mode),
        .i_burst_cnt(burst_cnt),
        .o_led_out(led_out),
        .o_frame_done(frame_done),
        .o_tick(tick)
    );

    // Model: per channel, mode kind plus ticks since restart (blink) or a frame
    // pattern of per-tick LED levels and a position in it (burst).
    int m_presc;
    int m_kind   [NUM_CH];
    int m_mode_q [NUM_CH];
    int m_ticks  [NUM_CH];
    bit m_pat    [NUM_CH][PAT_MAX];
    int m_len    [NUM_CH];
    int m_pos    [NUM_CH];
    bit m_fd     [NUM_CH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit level(input int c);
        case (m_kind[c])
            1:       return 1'b1;
            2:       return ((m_ticks[c] / BLINK_TICKS) % 2) == 0;
            3:       return m_pat[c][m_pos[c]];
            default: return 1'b0;
        endcase
    endfunction

    task automatic build_frame(input int c, input int n);
        int len = 0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < BURST_ON; j++) begin m_pat[c][len] = 1'b1; len++; end
            for (int j = 0; j < BURST_OFF; j++) begin m_pat[c][len] = 1'b0; len++; end
        end
        for (int j = 0; j < BURST_GAP; j++) begin m_pat[c][len] = 1'b0; len++; end
        m_len[c] = len;
        m_pos[c] = 0;
    endtask

    task automatic model_reset();
        m_presc = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_kind[c] = 0; m_mode_q[c] = 0; m_ticks[c] = 0;
            m_len[c] = 0; m_pos[c] = 0; m_fd[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit tk;
        int md;
        if (!rst_n || !enable) begin
            model_reset();
            return;
        end
        tk = (m_presc == TICK_DIV - 1);
        m_presc = tk ? 0 : m_presc + 1;
        for (int c = 0; c < NUM_CH; c++) begin
            m_fd[c] = 1'b0;
            md = int'(mode[2*c +: 2]);
            if (md != m_mode_q[c]) begin
                m_kind[c]  = md;
                m_ticks[c] = 0;
                if (md == 3) build_frame(c, int'(burst_cnt[CNT_W*c +: CNT_W]));
            end else if (tk) begin
                if (m_kind[c] == 2) begin
                    m_ticks[c]++;
                end else if (m_kind[c] == 3) begin
                    m_pos[c]++;
                    if (m_pos[c] == m_len[c]) begin
                        m_fd[c] = 1'b1;
                        build_frame(c, int'(burst_cnt[CNT_W*c +: CNT_W]));
                    end
                end
            end
            m_mode_q[c] = md;
        end
    endtask

    task automatic compare_outputs(input string where);
        logic [NUM_CH-1:0] e_led;
        logic [NUM_CH-1:0] e_fd;
        for (int c = 0; c < NUM_CH; c++) begin
            e_led[c] = level(c);
            e_fd[c]  = m_fd[c];
        end
        check_val({where, "/led_out"}, 32'(led_out), 32'(e_led));
        check_val({where, "/frame_done"}, 32'(frame_done), 32'(e_fd));
        check_val({where, "/tick"}, 32'(tick), 32'(m_presc == TICK_DIV - 1));
    endtask

    task automatic step(input string where);
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs(where);
        #1;
    endtask

    task automatic set_mode(input int c, input int m);
        mode[2*c +: 2] = 2'(m);
    endtask

    task automatic set_cnt(input int c, input int n);
        burst_cnt[CNT_W*c +: CNT_W] = CNT_W'(n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi_cnt;
        int waited;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs("reset");
        step("reset_hold");
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (8) step("prescaler");

        set_mode(0, 1);
        repeat (6) step("on");
        set_mode(0, 0);
        repeat (3) step("off");

        set_mode(1, 2);
        repeat (40) step("blink");
        enable = 1'b0;
        step("enable_low");
        enable = 1'b1;
        repeat (20) step("blink_reen");

        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs("async_reset");
        @(posedge clk);
        #2;
        step("reset_mid");
        rst_n = 1'b1;
        repeat (12) step("blink_after_rst");

        set_mode(1, 0);
        set_cnt(0, 3);
        set_mode(0, 3);
        repeat (80) step("burst3");

        set_cnt(0, 0);
        set_mode(0, 0);
        step("burst_off");
        set_mode(0, 3);
        repeat (40) step("burst0");

        set_mode(0, 0);
        step("burst_off2");
        set_cnt(0, 2);
        set_mode(0, 3);
        repeat (6) step("burst2");
        set_cnt(0, 4);
        repeat (90) step("burst2to4");

        set_mode(1, 2);
        repeat (5) step("pre_tick_restart");
        waited = 0;
        while (m_presc != TICK_DIV - 1 && waited < 2 * TICK_DIV) begin
            step("tick_wait");
            waited++;
        end
        check_val("tick_found", 32'(m_presc == TICK_DIV - 1), 32'd1);
        set_cnt(1, 2);
        set_mode(1, 3);
        hi_cnt = 0;
        for (int k = 0; k < 2 * TICK_DIV; k++) begin
            step("tick_restart");
            if (led_out[1] && k == hi_cnt) hi_cnt++;
        end
        check_val("first_flash_len", 32'(hi_cnt), 32'(TICK_DIV * BURST_ON));

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!enable) enable = 1'b1;
            else if ($urandom_range(0, 299) == 0) enable = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 39) == 0) set_mode(c, int'($urandom_range(0, 3)));
                if ($urandom_range(0, 59) == 0) begin
                    if ($urandom_range(0, 3) == 0) set_cnt(c, int'($urandom_range(0, 15)));
                    else set_cnt(c, int'($urandom_range(0, 3)));
                end
            end
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
